// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered operands; single-cycle ops plus optional shift-add multiply (ALU_SEQ_MUL_EN).
// Latency: result one cycle after accept (multiply: WIDTH+1); DONE holds result/flags and blocks input until out_ready.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             negative
);

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_AND = 3'b010;
    localparam logic [2:0] F_OR  = 3'b011;
    localparam logic [2:0] F_MUL = 3'b100;
    localparam logic [2:0] F_SLT = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_carry;
    logic             r_negative;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_cry;

    assign w_accept = in_valid && w_in_ready;

    // Subtract as a + ~b + 1 so bit WIDTH is the "no borrow" carry directly.
    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
    assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_cry = 1'b0;
        case (f)
            F_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cry = w_sum[WIDTH];
                w_ovf = w_add_ovf;
            end
            F_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_cry = w_diff[WIDTH];
                w_ovf = w_sub_ovf;
            end
            F_AND: w_res = a & b;
            F_OR:  w_res = a | b;
            // Sign of the difference corrected by overflow gives true signed less-than.
            F_SLT: w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_sub_ovf};
            default: w_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] w_prod_nxt;

    assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    w_next = (f == F_MUL) ? S_EXEC : S_DONE;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_EXEC: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_carry    <= 1'b0;
            r_negative <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_cnt      <= '0;
`endif
        end else begin
`ifdef ALU_SEQ_MUL_EN
            if (w_accept && (f == F_MUL)) begin
                r_mcand  <= {{WIDTH{1'b0}}, a};
                r_mplier <= b;
                r_prod   <= '0;
                r_cnt    <= CNT_W'(WIDTH);
            end else
`endif
            if (w_accept) begin
                r_result   <= w_res;
                r_zero     <= (w_res == '0);
                r_overflow <= w_ovf;
                r_carry    <= w_cry;
                r_negative <= w_res[WIDTH-1];
            end
`ifdef ALU_SEQ_MUL_EN
            if (r_state == S_EXEC) begin
                r_prod   <= w_prod_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_result   <= w_prod_nxt[WIDTH-1:0];
                    r_zero     <= (w_prod_nxt[WIDTH-1:0] == '0);
                    r_overflow <= 1'b0;
                    r_carry    <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                    r_negative <= w_prod_nxt[WIDTH-1];
                end
            end
`endif
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign carry     = r_carry;
    assign negative  = r_negative;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32; multiply vectors only when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        carry;
    logic        negative;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .carry     (carry),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {zero, overflow, carry, negative}.
    function automatic logic [3:0] flags();
        return {zero, overflow, carry, negative};
    endfunction

    task automatic op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                      input logic [2:0] tf, input logic [31:0] er, input logic [3:0] ef);
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        a = ta; b = tb_; f = tf; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_res"}, 64'(result), 64'(er));
        chk({tag, "_flg"}, 64'(flags()), 64'(ef));
        @(posedge clk); #1;
        chk({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic mul(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic [31:0] er, input logic [3:0] ef);
        int n;
        logic rdy_seen;
        @(negedge clk);
        a = ta; b = tb_; f = 3'b100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        rdy_seen = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd33);
        chk({tag, "_rdy_low"}, 64'(rdy_seen), 64'd0);
        chk({tag, "_res"}, 64'(result), 64'(er));
        chk({tag, "_flg"}, 64'(flags()), 64'(ef));
        @(posedge clk); #1;
        chk({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask
`endif

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; f = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 64'(in_ready), 64'd1);
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_res", 64'(result), 64'd0);
        chk("rst_flg", 64'(flags()), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        //  tag        a             b             f       result        {z,o,c,n}
        op("add_ovf",  32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 4'b0101);
        op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 4'b1010);
        op("sub_neg",  32'h00000000, 32'h00000001, 3'b001, 32'hFFFFFFFF, 4'b0001);
        op("sub_eq",   32'h00000001, 32'h00000001, 3'b001, 32'h00000000, 4'b1010);
        op("sub_ovf",  32'h80000000, 32'h00000001, 3'b001, 32'h7FFFFFFF, 4'b0110);
        op("slt_a",    32'h80000000, 32'h00000001, 3'b101, 32'h00000001, 4'b0000);
        op("slt_b",    32'h00000000, 32'hFFFFFFFF, 3'b101, 32'h00000000, 4'b1000);
        op("slt_c",    32'hFFFFFFFF, 32'h00000000, 3'b101, 32'h00000001, 4'b0000);
        op("and",      32'hFFFFFFFF, 32'h12345678, 3'b010, 32'h12345678, 4'b0000);
        op("or_zero",  32'h00000000, 32'h00000000, 3'b011, 32'h00000000, 4'b1000);
        op("or_neg",   32'h80000000, 32'h0000000F, 3'b011, 32'h8000000F, 4'b0001);
        op("rsv110",   32'h00000005, 32'h00000003, 3'b110, 32'h00000000, 4'b1000);
        op("rsv111",   32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 32'h00000000, 4'b1000);

`ifdef ALU_SEQ_MUL_EN
        mul("mul_hi",  32'h00010000, 32'h00010000, 32'h00000000, 4'b1010);
        mul("mul_lo",  32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 4'b0001);

        // Reset in the middle of a multiply.
        @(negedge clk);
        a = 32'h0000FFFF; b = 32'h0000FFFF; f = 3'b100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_vld", 64'(out_valid), 64'd0);
        chk("mrst_rdy", 64'(in_ready), 64'd1);
        chk("mrst_res", 64'(result), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        op("mrst_add", 32'h00000002, 32'h00000003, 3'b000, 32'h00000005, 4'b0000);
`else
        op("mul_off",  32'h00010000, 32'h00010000, 3'b100, 32'h00000000, 4'b1000);
`endif

        // Backpressure: DONE holds output and ignores new operands.
        @(negedge clk);
        out_ready = 1'b0;
        a = 32'h00000002; b = 32'h00000003; f = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; f = 3'(i); in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_vld", 64'(out_valid), 64'd1);
            chk("bp_rdy", 64'(in_ready), 64'd0);
            chk("bp_res", 64'(result), 64'd5);
            chk("bp_flg", 64'(flags()), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_vld", 64'(out_valid), 64'd0);
        chk("bp_rel_rdy", 64'(in_ready), 64'd1);

        // Reset while DONE is stalled drops out_valid.
        @(negedge clk);
        out_ready = 1'b0;
        a = 32'hFFFFFFFF; b = 32'h00000001; f = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("drst_pre", 64'(out_valid), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("drst_vld", 64'(out_valid), 64'd0);
        chk("drst_flg", 64'(flags()), 64'd0);

        // Reset dominates an accept on the same edge.
        @(negedge clk);
        out_ready = 1'b1;
        a = 32'h00000001; b = 32'h00000001; f = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("rdom_vld", 64'(out_valid), 64'd0);
        chk("rdom_res", 64'(result), 64'd0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;

        op("final_add", 32'h00000002, 32'h00000003, 3'b000, 32'h00000005, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the lab's 32-bit combinational ALU.
- Keeps the same f-code operations and zero/overflow/carry/negative flags, generalised to WIDTH bits.
- Adds a registered operand stage, valid/ready flow control and an iterative multi-cycle shift-add multiply.
- Sits between the operand source (register file or test driver) and the writeback/flag consumer.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 4.
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle a/b/f valid.
- in_ready  output  1  block can accept an operand bundle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- f  input  3  operation: 000 add, 001 sub, 010 and, 011 or, 100 mul, 101 slt, 110/111 reserved.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result equals 0.
- overflow  output  1  signed overflow (add/sub only).
- carry  output  1  add: carry-out; sub: NOT borrow; mul: high product half non-zero.
- negative  output  1  result[WIDTH-1].

Behaviour:
- Reset, synchronous and active-high: state=IDLE, in_ready=1, out_valid=0, result=0, all flags 0, counter=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE: in_ready=1. An accept occurs on an edge with in_valid&&in_ready. On accept, a/b/f are registered.
  - f=100: go to EXEC, counter=WIDTH.
  - Any other f: compute and go to DONE on the same edge, so out_valid rises one cycle after the accepting edge.
- EXEC: in_ready=0. Each cycle performs one shift-add step on a 2*WIDTH partial product and decrements the counter. At counter==1, load result/flags and go to DONE. out_valid rises WIDTH+1 cycles after accept.
- DONE: out_valid=1, in_ready=0. result and flags are held stable until out_valid&&out_ready; the next edge then returns to IDLE. Minimum issue interval is 2 cycles for single-cycle ops.
- Add: full WIDTH+1-bit sum. carry=bit WIDTH. overflow=(a[W-1]==b[W-1])&&(result[W-1]!=a[W-1]).
- Sub: a+~b+1. carry=carry-out, i.e. 1 when a>=b unsigned. overflow=(a[W-1]!=b[W-1])&&(result[W-1]!=a[W-1]).
- Slt: result=1 if signed a<b, computed as diff_sign XOR sub_overflow (correct across overflow); carry=0, overflow=0.
- And/or: bitwise; carry=0, overflow=0.
- Mul: unsigned; result=low WIDTH bits; carry=|high WIDTH bits; overflow=0.
- Reserved f: result=0, zero=1, other flags 0; single-cycle latency.
- zero and negative always derive from the final result, including slt and mul.
- Inputs a/b/f/in_valid are ignored outside IDLE; the operand source must hold them until accept.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-EXEC or in DONE discards the in-flight op; out_valid drops on the reset edge.
- reset dominates an accept on the same edge.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: multiply datapath and EXEC state are built as described above.
- Undefined: EXEC and the multiplier are not built; f=100 behaves as a reserved code (result 0, zero=1, single-cycle latency).

Test Plan:
- WIDTH=32, add 7FFFFFFF+00000001 -> result 80000000, overflow=1, negative=1, carry=0, zero=0; out_valid exactly 1 cycle after accept.
- Add FFFFFFFF+00000001 -> result 0, zero=1, carry=1, overflow=0. Sub 0-1 -> FFFFFFFF, carry=0, negative=1. Sub 1-1 -> 0, zero=1, carry=1.
- Slt 80000000,00000001 -> 1. Slt 00000000,FFFFFFFF -> 0. Slt FFFFFFFF,00000000 -> 1. And FFFFFFFF,12345678 -> 12345678. Or 00000000,00000000 -> 0, zero=1.
- ALU_SEQ_MUL_EN defined: mul 00010000*00010000 -> result 0, carry=1, zero=1, out_valid 33 cycles after accept; in_ready=0 throughout. Mul 0000FFFF*0000FFFF -> FFFE0001, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, a/b changes ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert reset for 1 cycle mid-mul (cycle 10 of EXEC) -> next cycle out_valid=0, in_ready=1, result=0; a following add 2+3 returns 5 normally.
